// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU result-mux issue control with DIVU sequencing and Hi/Lo scoreboard.
// Optional stall counter built when ALU_STALL_CNT_EN is defined.
module alu_op_sequencer #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [5:0]       op_funct,
    output logic             op_ready,
    output logic             res_valid,
    output logic [5:0]       mux_sel,
    output logic             div_load,
    output logic             div_step,
    output logic             hilo_we,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [5:0] STEP_LAST = 6'(DIV_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [5:0] step_q, step_d;
    logic       res_valid_q, res_valid_d;
    logic [5:0] mux_sel_q, mux_sel_d;
    logic       illegal_q, illegal_d;

    logic is_single, is_divu, is_hazard, accept;

    always_comb begin
        is_single = 1'b0;
        is_divu   = 1'b0;
        is_hazard = 1'b0;
        case (op_funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL: is_single = 1'b1;
            F_MFHI, F_MFLO: begin
                is_single = 1'b1;
                is_hazard = 1'b1;
            end
            F_DIVU: begin
                is_divu   = 1'b1;
                is_hazard = 1'b1;
            end
            default: ;
        endcase
    end

    // WB is deliberately not busy: Hi/Lo readers and a follow-on DIVU may issue there.
    assign busy     = (state_q == S_LOAD) || (state_q == S_STEP);
    assign op_ready = !(busy && is_hazard);
    assign accept   = op_valid && op_ready;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: if (accept && is_divu) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_STEP;
                step_d  = 6'd0;
            end
            S_STEP: begin
                if (step_q == STEP_LAST) state_d = S_WB;
                else                     step_d  = step_q + 6'd1;
            end
            S_WB:   state_d = (accept && is_divu) ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_valid_d = accept && is_single;
        illegal_d   = accept && !is_single && !is_divu;
        mux_sel_d   = res_valid_d ? op_funct : mux_sel_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= 6'd0;
            res_valid_q <= 1'b0;
            mux_sel_q   <= F_ADD;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            res_valid_q <= res_valid_d;
            mux_sel_q   <= mux_sel_d;
            illegal_q   <= illegal_d;
        end
    end

    assign res_valid = res_valid_q;
    assign mux_sel   = mux_sel_q;
    assign illegal   = illegal_q;
    assign div_load  = (state_q == S_LOAD);
    assign div_step  = (state_q == S_STEP);
    assign hilo_we   = (state_q == S_WB);

`ifdef ALU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (op_valid && !op_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench with cycle-window reference model for alu_op_sequencer.
module tb_alu_op_sequencer;

    localparam int D     = 32;
    localparam int CNT_W = 16;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic [5:0]       op_funct = 6'd0;
    logic             op_ready, res_valid, div_load, div_step, hilo_we, busy, illegal;
    logic [5:0]       mux_sel;
    logic [CNT_W-1:0] stall_cnt;

    alu_op_sequencer #(.DIV_CYCLES(D), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_funct(op_funct),
        .op_ready(op_ready), .res_valid(res_valid), .mux_sel(mux_sel),
        .div_load(div_load), .div_step(div_step), .hilo_we(hilo_we),
        .busy(busy), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model: divide timing is a window of cycle numbers around the DIVU accept cycle
    bit         mv = 0;
    int         ds = -1;
    bit         rv_e = 0, ill_e = 0;
    logic [5:0] mux_e = F_ADD;
    int         stall_e = 0;

    // last sampled outputs and event history
    logic       s_rv, s_ill, s_load, s_step, s_we, s_busy, s_ready, s_acc;
    logic [5:0] s_mux;
    int         s_stall, s_cyc;
    int         last_we = -1, last_load = -1, we_count = 0, step_total = 0;

    function automatic bit known_single(input logic [5:0] f);
        return (f == F_AND) || (f == F_OR) || (f == F_ADD) || (f == F_SUB) ||
               (f == F_SLT) || (f == F_SRL) || (f == F_MFHI) || (f == F_MFLO);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        bit busy_e, load_e, step_e, we_e, ready_e, hazard, acc;
        busy_e = (ds >= 0) && (cyc >= ds + 1) && (cyc <= ds + 1 + D);
        load_e = (ds >= 0) && (cyc == ds + 1);
        step_e = (ds >= 0) && (cyc >= ds + 2) && (cyc <= ds + 1 + D);
        we_e   = (ds >= 0) && (cyc == ds + 2 + D);
        hazard = (op_funct == F_DIVU) || (op_funct == F_MFHI) || (op_funct == F_MFLO);
        ready_e = !(busy_e && hazard);

        s_rv = res_valid; s_ill = illegal; s_load = div_load; s_step = div_step;
        s_we = hilo_we; s_busy = busy; s_ready = op_ready; s_mux = mux_sel;
        s_stall = int'(stall_cnt); s_cyc = cyc;
        s_acc = op_valid && op_ready && rst_n;
        if (hilo_we === 1'b1) begin last_we = cyc; we_count++; end
        if (div_load === 1'b1) last_load = cyc;
        if (div_step === 1'b1) step_total++;

        if (mv) begin
            chk("res_valid", 32'(res_valid), 32'(rv_e));
            chk("mux_sel",   32'(mux_sel),   32'(mux_e));
            chk("illegal",   32'(illegal),   32'(ill_e));
            chk("div_load",  32'(div_load),  32'(load_e));
            chk("div_step",  32'(div_step),  32'(step_e));
            chk("hilo_we",   32'(hilo_we),   32'(we_e));
            chk("busy",      32'(busy),      32'(busy_e));
            chk("op_ready",  32'(op_ready),  32'(ready_e));
            chk("stall_cnt", 32'(stall_cnt), 32'(stall_e));
        end

        if (!rst_n) begin
            mv = 1; ds = -1; rv_e = 0; ill_e = 0; mux_e = F_ADD; stall_e = 0;
        end else if (mv) begin
            acc   = op_valid && ready_e;
            rv_e  = acc && known_single(op_funct);
            ill_e = acc && !known_single(op_funct) && (op_funct != F_DIVU);
            if (rv_e) mux_e = op_funct;
            if (acc && op_funct == F_DIVU) ds = cyc;
`ifdef ALU_STALL_CNT_EN
            if (op_valid && !ready_e && stall_e < (1 << CNT_W) - 1) stall_e++;
`endif
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic r);
        op_valid = v; op_funct = f; rst_n = r;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, F_ADD, 1'b1);
    endtask

    int t0, t1, acc_cyc, st0, steps0, we0;

    initial begin
        @(posedge clk);
        #1;
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
        idle(1);
        chk("lit_reset_mux", 32'(s_mux), 32'(F_ADD));
        chk("lit_reset_rv", 32'(s_rv), 32'd0);
        chk("lit_reset_busy", 32'(s_busy), 32'd0);
        chk("lit_reset_ready", 32'(s_ready), 32'd1);

        drive(1'b1, F_ADD, 1'b1);
        drive(1'b1, F_SUB, 1'b1);
        chk("lit_add", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b100000});
        drive(1'b1, F_SLT, 1'b1);
        chk("lit_sub", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b100010});
        drive(1'b1, F_SRL, 1'b1);
        chk("lit_slt", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b101010});
        idle(1);
        chk("lit_srl", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b000010});
        idle(1);
        chk("lit_hold", {26'd0, s_rv, s_mux}, {26'd0, 1'b0, 6'b000010});

        // DIVU then MFHI held until the Hi/Lo scoreboard frees it
        t0 = cyc; steps0 = step_total;
        drive(1'b1, F_DIVU, 1'b1);
        st0 = s_stall;
        acc_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, F_MFHI, 1'b1);
            if (s_acc) begin acc_cyc = s_cyc; break; end
        end
        chk("lit_mfhi_accept", 32'(acc_cyc), 32'(t0 + 34));
        chk("lit_load_cyc", 32'(last_load), 32'(t0 + 1));
        chk("lit_we_cyc", 32'(last_we), 32'(t0 + 34));
        chk("lit_steps", 32'(step_total - steps0), 32'd32);
        idle(1);
        chk("lit_mfhi_res", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b010000});
`ifdef ALU_STALL_CNT_EN
        chk("lit_stall33", 32'(s_stall - st0), 32'd33);
`else
        chk("lit_stall0", 32'(s_stall), 32'd0);
`endif

        // independent ALU ops issue under a divide
        t0 = cyc; steps0 = step_total;
        drive(1'b1, F_DIVU, 1'b1);
        idle(1);
        drive(1'b1, F_AND, 1'b1);
        drive(1'b1, F_OR, 1'b1);
        chk("lit_and", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b100100});
        idle(1);
        chk("lit_or", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b100101});
        idle(36);
        chk("lit_we_under_alu", 32'(last_we), 32'(t0 + 34));
        chk("lit_steps_unbroken", 32'(step_total - steps0), 32'd32);

        // illegal funct and MFLO while idle
        drive(1'b1, 6'b111111, 1'b1);
        idle(1);
        chk("lit_illegal", {26'd0, s_ill, s_rv, s_mux}, {26'd0, 1'b1, 1'b0, 6'b100101});
        drive(1'b1, F_MFLO, 1'b1);
        chk("lit_illegal_once", 32'(s_ill), 32'd0);
        idle(1);
        chk("lit_mflo", {26'd0, s_rv, s_mux}, {26'd0, 1'b1, 6'b010010});

        // reset mid-divide aborts without a Hi/Lo write
        t0 = cyc;
        drive(1'b1, F_DIVU, 1'b1);
        idle(9);
        drive(1'b0, 6'd0, 1'b0);
        we0 = we_count;
        idle(1);
        chk("lit_abort_state", {29'd0, s_busy, s_step, s_load}, 32'd0);
        chk("lit_abort_mux", 32'(s_mux), 32'(F_ADD));
        idle(40);
        chk("lit_abort_no_we", 32'(we_count - we0), 32'd0);
        t1 = cyc; steps0 = step_total;
        drive(1'b1, F_DIVU, 1'b1);
        idle(36);
        chk("lit_rerun_we", 32'(last_we), 32'(t1 + 34));
        chk("lit_rerun_steps", 32'(step_total - steps0), 32'd32);

        // back-to-back DIVU accepted in WB
        t0 = cyc;
        drive(1'b1, F_DIVU, 1'b1);
        acc_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, F_DIVU, 1'b1);
            if (s_acc) begin acc_cyc = s_cyc; break; end
        end
        chk("lit_b2b_accept", 32'(acc_cyc), 32'(t0 + 34));
        idle(1);
        chk("lit_b2b_load", 32'(s_load), 32'd1);
        idle(36);
        chk("lit_b2b_we", 32'(last_we), 32'(acc_cyc + 34));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
